// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic stage with valid/ready handshakes and an OR-accumulate mode
// that folds a multi-beat stream into a single result.
module logic_unit_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] Y,
    output logic             Y_any,
    output logic [CNT_W-1:0] beats,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [2:0] OpAnd  = 3'd0;
    localparam logic [2:0] OpOr   = 3'd1;
    localparam logic [2:0] OpXor  = 3'd2;
    localparam logic [2:0] OpNand = 3'd3;
    localparam logic [2:0] OpNor  = 3'd4;
    localparam logic [2:0] OpXnor = 3'd5;
    localparam logic [2:0] OpAcc  = 3'd6;

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             y_any_q, y_any_d;
    logic [CNT_W-1:0] beats_q, beats_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic [WIDTH-1:0] op_res;
    logic [WIDTH-1:0] acc_sum;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [CNT_W-1:0] load_beats;

    // Single-entry output register: a result may be replaced in the cycle it is consumed.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    assign Y         = y_q;
    assign Y_any     = y_any_q;
    assign beats     = beats_q;
    assign out_valid = out_valid_q;

    always_comb begin
        op_res = '0;
        case (op)
            OpAnd:   op_res = A & B;
            OpOr:    op_res = A | B;
            OpXor:   op_res = A ^ B;
            OpNand:  op_res = ~(A & B);
            OpNor:   op_res = ~(A | B);
            OpXnor:  op_res = ~(A ^ B);
            OpAcc:   op_res = A | B;
            default: op_res = ~A;
        endcase
    end

    assign acc_sum = acc_q | A | B;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        y_d         = y_q;
        y_any_d     = y_any_q;
        beats_d     = beats_q;
        out_valid_d = out_valid_q && !out_ready;
        load        = 1'b0;
        load_val    = '0;
        load_beats  = '0;

        if (accept) begin
            case (state_q)
                StIdle: begin
                    if (op == OpAcc && !in_last) begin
                        acc_d   = A | B;
                        cnt_d   = CNT_W'(1);
                        state_d = StAccum;
                    end else begin
                        load       = 1'b1;
                        load_val   = op_res;
                        load_beats = CNT_W'(1);
                    end
                end
                StAccum: begin
                    // All-ones counter means this beat is number 2**CNT_W: forced flush.
                    if (in_last || cnt_q == '1) begin
                        load       = 1'b1;
                        load_val   = acc_sum;
                        load_beats = cnt_q + CNT_W'(1);
                        acc_d      = '0;
                        cnt_d      = '0;
                        state_d    = StIdle;
                    end else begin
                        acc_d = acc_sum;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (load) begin
            y_d         = load_val;
            y_any_d     = |load_val;
            beats_d     = load_beats;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            y_q         <= '0;
            y_any_q     <= 1'b0;
            beats_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            y_q         <= y_d;
            y_any_q     <= y_any_d;
            beats_q     <= beats_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
